// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and code-table types for the Huffman decoder.
package huffman_pkg;

    localparam int NSYM   = 6;
    localparam int CODE_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [CODE_W-1:0] mask;
    } code_entry_t;

    // Entry 0 holds symbol 1.
    typedef code_entry_t [NSYM-1:0] code_table_t;

endpackage

// File: rtl/huffman_match.sv
// Combinational compare of the candidate codeword against all six table entries;
// the lowest-numbered matching symbol wins.
module huffman_match
    import huffman_pkg::*;
(
    input  logic [CODE_W-1:0] acc_n,
    input  logic [CODE_W-1:0] mask_n,
    input  code_table_t       tbl,
    output logic              hit,
    output logic [2:0]        idx
);

    logic [NSYM-1:0] match_s;

    // Per-entry compare; an entry with mask 0 can never equal a non-zero mask_n.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NSYM; i++) begin
            match_s[i] = (tbl[i].mask == mask_n) && ((acc_n & tbl[i].mask) == tbl[i].code);
        end
    end

    // Priority encode to a 1-based symbol index.
    always_comb begin
        hit = |match_s;
        casez (match_s)
            6'b?????1: idx = 3'd1;
            6'b????10: idx = 3'd2;
            6'b???100: idx = 3'd3;
            6'b??1000: idx = 3'd4;
            6'b?10000: idx = 3'd5;
            6'b100000: idx = 3'd6;
            default:   idx = 3'd0;
        endcase
    end

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: latches a six-entry code table, shifts in code bits and
// emits one registered symbol per complete codeword, counting symbols per frame.
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int FRAME_LEN = 100,
    parameter int MAX_LEN   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       table_valid,
    input  logic [7:0] HC1,
    input  logic [7:0] HC2,
    input  logic [7:0] HC3,
    input  logic [7:0] HC4,
    input  logic [7:0] HC5,
    input  logic [7:0] HC6,
    input  logic [7:0] M1,
    input  logic [7:0] M2,
    input  logic [7:0] M3,
    input  logic [7:0] M4,
    input  logic [7:0] M5,
    input  logic [7:0] M6,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       ready,
    output logic       sym_valid,
    output logic [7:0] sym_data,
    output logic [7:0] sym_cnt,
    output logic       err,
    output logic       done
);

    code_table_t       tbl_r;
    logic [1:0]        state_r;
    logic [1:0]        state_n_s;
    logic [CODE_W-1:0] acc_r;
    logic [3:0]        len_r;
    logic [7:0]        sym_cnt_r;
    logic              ready_r;
    logic              sym_valid_r;
    logic [7:0]        sym_data_r;
    logic              err_r;
    logic              done_r;

    logic [CODE_W-1:0] acc_n_s;
    logic [3:0]        len_n_s;
    logic [CODE_W-1:0] mask_n_s;
    logic              accept_s;
    logic              hit_s;
    logic [2:0]        idx_s;
    logic [7:0]        cnt_inc_s;
    logic              frame_end_s;
    logic              max_len_s;

    assign acc_n_s   = {acc_r[CODE_W-2:0], bit_in};
    assign len_n_s   = len_r + 4'd1;
    assign mask_n_s  = 8'hFF >> (4'd8 - len_n_s);
    // A table load takes priority over any bit presented in the same cycle.
    assign accept_s  = (state_r == RUN) && bit_valid && !table_valid;
    assign cnt_inc_s = (sym_cnt_r == 8'hFF) ? 8'hFF : (sym_cnt_r + 8'd1);
    assign max_len_s = (len_n_s == 4'(MAX_LEN));
    assign frame_end_s = accept_s && hit_s && (cnt_inc_s == 8'(FRAME_LEN));

    huffman_match u_match (
        .acc_n  (acc_n_s),
        .mask_n (mask_n_s),
        .tbl    (tbl_r),
        .hit    (hit_s),
        .idx    (idx_s)
    );

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (table_valid) state_n_s = RUN;
                else             state_n_s = IDLE;
            end
            RUN: begin
                if (table_valid)      state_n_s = RUN;
                else if (frame_end_s) state_n_s = DONE;
                else                  state_n_s = RUN;
            end
            DONE: begin
                if (table_valid) state_n_s = RUN;
                else             state_n_s = DONE;
            end
            default: state_n_s = IDLE;
        endcase
    end

    // Table, shift register, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tbl_r       <= '0;
            state_r     <= IDLE;
            acc_r       <= '0;
            len_r       <= 4'd0;
            sym_cnt_r   <= 8'd0;
            ready_r     <= 1'b0;
            sym_valid_r <= 1'b0;
            sym_data_r  <= 8'd0;
            err_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            ready_r     <= (state_n_s == RUN);
            sym_valid_r <= 1'b0;
            err_r       <= 1'b0;
            if (table_valid) begin
                tbl_r[0]  <= '{code: HC1, mask: M1};
                tbl_r[1]  <= '{code: HC2, mask: M2};
                tbl_r[2]  <= '{code: HC3, mask: M3};
                tbl_r[3]  <= '{code: HC4, mask: M4};
                tbl_r[4]  <= '{code: HC5, mask: M5};
                tbl_r[5]  <= '{code: HC6, mask: M6};
                acc_r     <= '0;
                len_r     <= 4'd0;
                sym_cnt_r <= 8'd0;
                done_r    <= 1'b0;
            end else if (accept_s) begin
                if (hit_s) begin
                    sym_valid_r <= 1'b1;
                    sym_data_r  <= {5'd0, idx_s};
                    acc_r       <= '0;
                    len_r       <= 4'd0;
                    sym_cnt_r   <= cnt_inc_s;
                    if (frame_end_s) done_r <= 1'b1;
                    else             done_r <= done_r;
                end else if (max_len_s) begin
                    err_r <= 1'b1;
                    acc_r <= '0;
                    len_r <= 4'd0;
                end else begin
                    acc_r <= acc_n_s;
                    len_r <= len_n_s;
                end
            end else begin
                acc_r <= acc_r;
                len_r <= len_r;
            end
        end
    end

    assign ready     = ready_r;
    assign sym_valid = sym_valid_r;
    assign sym_data  = sym_data_r;
    assign sym_cnt   = sym_cnt_r;
    assign err       = err_r;
    assign done      = done_r;

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: stimulus queues expected symbols/errors,
// a negedge monitor pops and compares whenever the DUT pulses sym_valid or err.
module tb_huffman_decoder;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [7:0] cnt;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       table_valid = 1'b0;
    logic [7:0] hc_v [6];
    logic [7:0] m_v [6];
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       ready;
    logic       sym_valid;
    logic [7:0] sym_data;
    logic [7:0] sym_cnt;
    logic       err;
    logic       done;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    huffman_decoder #(.FRAME_LEN(4), .MAX_LEN(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .table_valid (table_valid),
        .HC1         (hc_v[0]),
        .HC2         (hc_v[1]),
        .HC3         (hc_v[2]),
        .HC4         (hc_v[3]),
        .HC5         (hc_v[4]),
        .HC6         (hc_v[5]),
        .M1          (m_v[0]),
        .M2          (m_v[1]),
        .M3          (m_v[2]),
        .M4          (m_v[3]),
        .M5          (m_v[4]),
        .M6          (m_v[5]),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .ready       (ready),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .sym_cnt     (sym_cnt),
        .err         (err),
        .done        (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && (sym_valid || err)) begin
            exp_t e;
            if (sym_valid && err) begin
                total++;
                bad++;
                $display("FAIL excl: got sym_valid=1 err=1 expected not both");
            end
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected: got sym_valid=%0b err=%0b data=%0h expected no output",
                         sym_valid, err, sym_data);
            end else begin
                e = exp_q.pop_front();
                check("kind_err", {31'd0, err}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    check("sym_data", {24'd0, sym_data}, {24'd0, e.data});
                    check("sym_cnt", {24'd0, sym_cnt}, {24'd0, e.cnt});
                    check("done", {31'd0, done}, {31'd0, e.done});
                end
            end
        end
    end

    task automatic set_table_t();
        hc_v = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        m_v  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    endtask

    task automatic load(input logic bv, input logic bi);
        table_valid = 1'b1;
        bit_valid = bv;
        bit_in = bi;
        @(posedge clk);
        #1;
        table_valid = 1'b0;
        bit_valid = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in = b;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_sym(input logic [7:0] d, input logic [7:0] c, input logic dn);
        exp_q.push_back('{is_err: 1'b0, data: d, cnt: c, done: dn});
    endtask

    task automatic expect_err();
        exp_q.push_back('{is_err: 1'b1, data: 8'd0, cnt: 8'd0, done: 1'b0});
    endtask

    task automatic drain(input string name);
        idle(3);
        check(name, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        set_table_t();
        reset = 1'b1;
        idle(2);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
        check("rst_cnt", {24'd0, sym_cnt}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        idle(1);

        // 1: single one-bit codeword, one cycle latency
        load(1'b0, 1'b0);
        check("t1_ready", {31'd0, ready}, 32'd1);
        expect_sym(8'd1, 8'd1, 1'b0);
        send_bit(1'b1);
        check("t1_latency", {31'd0, sym_valid}, 32'd1);
        drain("t1_drain");

        // 2: mixed stream -> 2,3,6
        load(1'b0, 1'b0);
        send_bit(1'b0);
        expect_sym(8'd2, 8'd1, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        expect_sym(8'd3, 8'd2, 1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        expect_sym(8'd6, 8'd3, 1'b0);
        send_bit(1'b0);
        drain("t2_drain");
        check("t2_cnt", {24'd0, sym_cnt}, 32'd3);

        // 3: symbol 6 unused -> eight zeros give an error, then recovery
        m_v[5] = 8'h00;
        load(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        expect_err();
        send_bit(1'b0);
        check("t3_err_pulse", {31'd0, err}, 32'd1);
        check("t3_cnt_hold", {24'd0, sym_cnt}, 32'd0);
        expect_sym(8'd1, 8'd1, 1'b0);
        send_bit(1'b1);
        drain("t3_drain");
        set_table_t();

        // 4: frame of four symbols with gaps, then DONE ignores bits
        load(1'b0, 1'b0);
        expect_sym(8'd1, 8'd1, 1'b0);
        send_bit(1'b1);
        idle(2);
        expect_sym(8'd1, 8'd2, 1'b0);
        send_bit(1'b1);
        idle(1);
        expect_sym(8'd1, 8'd3, 1'b0);
        send_bit(1'b1);
        idle(3);
        expect_sym(8'd1, 8'd4, 1'b1);
        send_bit(1'b1);
        check("t4_ready", {31'd0, ready}, 32'd0);
        check("t4_done", {31'd0, done}, 32'd1);
        send_bit(1'b1);
        send_bit(1'b1);
        drain("t4_drain");
        check("t4_cnt", {24'd0, sym_cnt}, 32'd4);
        check("t4_done_hold", {31'd0, done}, 32'd1);

        // 5: partial code discarded by a reload; bit during reload is ignored
        load(1'b0, 1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        load(1'b1, 1'b1);
        check("t5_done_clr", {31'd0, done}, 32'd0);
        check("t5_cnt_clr", {24'd0, sym_cnt}, 32'd0);
        expect_sym(8'd1, 8'd1, 1'b0);
        send_bit(1'b1);
        drain("t5_drain");

        // 6: async reset mid-codeword
        load(1'b0, 1'b0);
        expect_sym(8'd1, 8'd1, 1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        #2 reset = 1'b1;
        #1;
        check("t6_async_cnt", {24'd0, sym_cnt}, 32'd0);
        check("t6_async_ready", {31'd0, ready}, 32'd0);
        check("t6_async_done", {31'd0, done}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        idle(2);
        check("t6_idle_cnt", {24'd0, sym_cnt}, 32'd0);
        check("t6_idle_ready", {31'd0, ready}, 32'd0);
        load(1'b0, 1'b0);
        expect_sym(8'd1, 8'd1, 1'b0);
        send_bit(1'b1);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
